ternary_sched: RTL
==================

Name: ternary_sched

Overview:
- Controller and arbiter for the shared mod-3 lane array in the NTRU-HRSS ternary sampler.
- Two clients share one lane array: client 0 samples f, client 1 samples g.
- Per granted job, streams packed sample bytes from a word RAM through LANES mod-3 lanes and writes the 2-bit ternary coefficients to the coefficient buffer.
- Signals completion to the client that owned the job.

Parameters:
- NUM_COEF, 700: coefficients per job. One sample byte per coefficient. Must be divisible by LANES.
- LANES, 4: mod-3 lanes processed per cycle.
- LAT, 2: fixed lane latency in cycles, from lane_vld to the matching lane_out.
- AW, 8: address width. Must satisfy 2^AW ≥ NUM_COEF/LANES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req  in  2  per-client request; held high until done
- gnt  out  2  one-hot grant; high for the whole job
- done  out  2  one-cycle completion pulse to the owner
- busy  out  1  high in any state other than IDLE
- rd_en  out  1  sample RAM read strobe
- rd_addr  out  AW  sample word address
- rd_data  in  8*LANES  sample word; valid exactly 1 cycle after rd_en
- lane_in  out  8*LANES  byte j goes to lane j
- lane_vld  out  1  lane input valid
- lane_out  in  2*LANES  lane results; bits [2j+1:2j] come from lane j
- wr_en  out  1  coefficient write strobe
- wr_addr  out  AW  coefficient word address
- wr_data  out  2*LANES  packed coefficients
- wr_sel  out  1  owner id; selects f or g buffer

Behaviour:
- Derived constant: WORDS = NUM_COEF/LANES, 175 by default.
- Reset values:
  - State IDLE.
  - All outputs 0.
  - Address counters 0.
  - Valid pipeline cleared.
  - Round-robin pointer prefers client 0.
- IDLE:
  - If any req is high, choose an owner.
  - Single requester: that client wins.
  - Both requesting: the client not served last wins (pointer).
  - Latch owner, assert gnt[owner], go to RUN.
- RUN:
  - rd_en=1 every cycle with rd_addr = 0..WORDS-1.
  - Move to DRAIN after issuing address WORDS-1.
- Datapath, a fixed pipeline with no backpressure:
  - lane_vld = rd_en delayed by 1 cycle.
  - lane_in = rd_data.
  - wr_en = lane_vld delayed by LAT cycles.
  - wr_data = lane_out.
  - wr_addr increments from 0 on each write.
  - wr_sel = owner.
  - Coefficient index = word*LANES + j.
  - Coefficient encoding: 00 = 0, 01 = 1, 10 = 2.
- DRAIN: wait until the valid pipeline is empty (last wr_en done), then go to DONE.
- DONE:
  - done[owner]=1 for one cycle.
  - gnt drops in the same cycle.
  - Pointer is set to owner.
  - Next state IDLE.
- Latency from gnt rising (RUN entry = cycle 0):
  - rd_en in cycles 0..WORDS-1.
  - wr_en in cycles 1+LAT..WORDS+LAT.
  - done in cycle WORDS+LAT+1, which is 178 by default.
  - Back-to-back gnt is possible 1 cycle after done.
- Arbitration timing:
  - A req rising during a job waits and is not queued beyond the level of req.
  - req of the owner dropping mid-job is ignored in the base build.
- Reset mid-job:
  - Immediate return to IDLE with all outputs 0.
  - No done, no further writes.
- Invariants:
  - gnt is at most one-hot.
  - wr_en never asserts without a matching earlier lane_vld.

Optional Feature:
- Macro: TERNARY_SCHED_ABORT_EN.
- Defined:
  - If req[owner] falls during RUN, stop issuing reads on the next cycle and enter DRAIN.
  - In-flight writes complete.
  - No done pulse is produced.
  - gnt drops on the IDLE return.
  - Pointer is still updated.
- Undefined: req drop is ignored; the job always runs to completion.

Decomposition:
- Shared package ternary_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}.
  - Coefficient encoding constants TRIT_ZERO, TRIT_ONE, TRIT_TWO.
  - Default NUM_COEF and LANES.
  - A function computing WORDS.
- Sub-module ternary_rr_arb:
  - 2-way round-robin arbiter.
  - Inputs: req, update, last owner.
  - Output: one-hot grant.

Test Plan:
- Single job:
  - Stimulus: req=01; RAM word k holds bytes {k, k+1, k+2, k+3}; model lanes as byte mod 3 with LAT=2.
  - Response: 175 writes; wr_addr 0..174; wr_data matches the model (word 0 → {00,01,10,00}); wr_sel=0; done=01 at cycle 178.
- Simultaneous requests:
  - Stimulus: req=11 from reset.
  - Response: client 0 served first; client 1 granted 1 cycle after done[0]; wr_sel=1; done=10 at its cycle 178.
- Fairness:
  - Stimulus: req=11 held for 4 jobs.
  - Response: grant sequence 0,1,0,1; gnt never 11.
- Late request:
  - Stimulus: req[1] rises at cycle 50 of a client-0 job.
  - Response: no change to the running job; client 1 granted after done[0].
- Reset mid-job:
  - Stimulus: rst at cycle 100.
  - Response: next cycle gnt=0, busy=0, no wr_en; a fresh req=01 restarts at rd_addr 0.
- Abort (TERNARY_SCHED_ABORT_EN):
  - Stimulus: req[0] drops at cycle 20.
  - Response: last rd_addr is 19 or 20; writes match issued reads; no done pulse; busy falls afterwards.

Source files
------------

// File: rtl/ternary_pkg.sv
// Shared definitions for the ternary sampler lane-array scheduler:
// FSM state encoding, ternary coefficient codes, default geometry and a
// helper that derives the number of sample words per job.
package ternary_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // 2-bit ternary coefficient codes produced by the mod-3 lanes
   localparam logic [1:0] TRIT_ZERO = 2'b00;
   localparam logic [1:0] TRIT_ONE  = 2'b01;
   localparam logic [1:0] TRIT_TWO  = 2'b10;

   localparam int DEF_NUM_COEF = 700;
   localparam int DEF_LANES    = 4;

   // One sample byte per coefficient, LANES bytes per RAM word
   function automatic int num_words(input int num_coef, input int lanes);
      return num_coef / lanes;
   endfunction

endpackage

// File: rtl/ternary_rr_arb.sv
// Two-way round-robin arbiter. The pointer remembers the client served
// last; on a tie the other client wins. After reset client 0 is preferred.
module ternary_rr_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       last_owner,
   output logic [1:0] gnt
);

   logic ptr_q;
   logic ptr_d;

   // Pointer follows the owner of the job that just finished
   always_comb begin
      ptr_d = ptr_q;
      if (update) begin
         ptr_d = last_owner;
      end
   end

   // Pointer register; reset value 1 makes client 0 the first tie winner
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= 1'b1;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // One-hot grant: single requester wins, tie goes to the client not served last
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = ptr_q ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/ternary_sched.sv
// Scheduler for the shared mod-3 lane array of the NTRU-HRSS ternary
// sampler. Arbitrates between the f (client 0) and g (client 1) samplers,
// streams sample words through the lanes and writes packed trits to the
// coefficient buffer selected by wr_sel.
// Optional build macro TERNARY_SCHED_ABORT_EN: an owner dropping req during
// RUN aborts the job (reads stop, in-flight writes finish, no done pulse).
module ternary_sched
   import ternary_pkg::*;
#(
   parameter int NUM_COEF = DEF_NUM_COEF,
   parameter int LANES    = DEF_LANES,
   parameter int LAT      = 2,
   parameter int AW       = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           req,
   output logic [1:0]           gnt,
   output logic [1:0]           done,
   output logic                 busy,
   output logic                 rd_en,
   output logic [AW-1:0]        rd_addr,
   input  logic [8*LANES-1:0]   rd_data,
   output logic [8*LANES-1:0]   lane_in,
   output logic                 lane_vld,
   input  logic [2*LANES-1:0]   lane_out,
   output logic                 wr_en,
   output logic [AW-1:0]        wr_addr,
   output logic [2*LANES-1:0]   wr_data,
   output logic                 wr_sel
);

   localparam int            WORDS     = num_words(NUM_COEF, LANES);
   localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

   state_t        state_q, state_d;
   logic [1:0]    gnt_q, gnt_d;
   logic [1:0]    done_q, done_d;
   logic          owner_q, owner_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   // vld_q[0] is lane_vld, vld_q[LAT] is wr_en
   logic [LAT:0]  vld_q, vld_d;
   logic [1:0]    arb_gnt;
   logic          arb_update;
   logic          issue;
`ifdef TERNARY_SCHED_ABORT_EN
   logic          abort_q, abort_d;
`endif

   ternary_rr_arb u_arb (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .update     (arb_update),
      .last_owner (owner_q),
      .gnt        (arb_gnt)
   );

   assign issue = (state_q == RUN);

   // Job control: arbitrate in IDLE, issue reads in RUN, wait out the lane
   // pipeline in DRAIN, pulse done in DONE
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      done_d     = 2'b00;
      owner_d    = owner_q;
      rd_addr_d  = rd_addr_q;
      arb_update = 1'b0;
`ifdef TERNARY_SCHED_ABORT_EN
      abort_d    = abort_q;
`endif
      case (state_q)
         IDLE: begin
            rd_addr_d = '0;
`ifdef TERNARY_SCHED_ABORT_EN
            abort_d   = 1'b0;
`endif
            if (arb_gnt != 2'b00) begin
               owner_d = arb_gnt[1];
               gnt_d   = arb_gnt;
               state_d = RUN;
            end
         end
         RUN: begin
            rd_addr_d = rd_addr_q + AW'(1);
            if (rd_addr_q == LAST_ADDR) begin
               rd_addr_d = '0;
               state_d   = DRAIN;
            end
`ifdef TERNARY_SCHED_ABORT_EN
            else if (!req[owner_q]) begin
               rd_addr_d = '0;
               state_d   = DRAIN;
               abort_d   = 1'b1;
            end
`endif
         end
         DRAIN: begin
            // Only the last stage still holding data means the final write
            // happens this cycle, so the job ends on the next one
            if (vld_q[LAT-1:0] == '0) begin
               gnt_d = 2'b00;
`ifdef TERNARY_SCHED_ABORT_EN
               if (abort_q) begin
                  state_d    = IDLE;
                  arb_update = 1'b1;
               end else
`endif
               begin
                  state_d = DONE;
                  done_d  = gnt_q;
               end
            end
         end
         DONE: begin
            state_d    = IDLE;
            arb_update = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Valid pipeline: read issue -> lane input valid -> write after LAT cycles
   always_comb begin
      vld_d = {vld_q[LAT-1:0], issue};
   end

   // Write address counts completed writes within the job
   always_comb begin
      wr_addr_d = wr_addr_q;
      if (state_q == IDLE) begin
         wr_addr_d = '0;
      end else if (vld_q[LAT]) begin
         wr_addr_d = wr_addr_q + AW'(1);
      end
   end

   // State and datapath registers, all cleared by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         gnt_q     <= 2'b00;
         done_q    <= 2'b00;
         owner_q   <= 1'b0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         vld_q     <= '0;
`ifdef TERNARY_SCHED_ABORT_EN
         abort_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         owner_q   <= owner_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         vld_q     <= vld_d;
`ifdef TERNARY_SCHED_ABORT_EN
         abort_q   <= abort_d;
`endif
      end
   end

   assign gnt      = gnt_q;
   assign done     = done_q;
   assign busy     = (state_q != IDLE);
   assign rd_en    = issue;
   assign rd_addr  = rd_addr_q;
   assign lane_vld = vld_q[0];
   assign lane_in  = vld_q[0] ? rd_data : '0;
   assign wr_en    = vld_q[LAT];
   assign wr_addr  = wr_addr_q;
   assign wr_data  = vld_q[LAT] ? lane_out : '0;
   assign wr_sel   = owner_q;

endmodule
